// File: rtl/pwm_capture_if.sv
// pwm_capture_if
// Bundles the measurement-side signals of pwm_capture.
//   cap_enable  : measurement enable (low forces IDLE)
//   cap_pulse   : PWM input
//   cap_period  : cycles between consecutive rising edges
//   cap_high    : cycles the input was high within that period
//   cap_valid   : one-cycle strobe, cap_period/cap_high are new
//   cap_timeout : one-cycle strobe, no rising edge within TIMEOUT cycles
//   cap_busy    : high while a reference edge is held (RUN)
//   cap_state   : debug view of the FSM state (0 = IDLE, 1 = RUN)
// Handshake: cap_valid/cap_timeout are fire-and-forget strobes with no
// ready; the consumer must sample cap_period/cap_high on the cap_valid cycle
// (the values then hold until the next cap_valid).
// The slave modport is the capture block, the master modport is its user.
interface pwm_capture_if #(
    parameter int WIDTH = 32
);
    logic             cap_enable;
    logic             cap_pulse;
    logic [WIDTH-1:0] cap_period;
    logic [WIDTH-1:0] cap_high;
    logic             cap_valid;
    logic             cap_timeout;
    logic             cap_busy;
    logic             cap_state;

    modport slave (
        input  cap_enable,
        input  cap_pulse,
        output cap_period,
        output cap_high,
        output cap_valid,
        output cap_timeout,
        output cap_busy,
        output cap_state
    );

    modport master (
        output cap_enable,
        output cap_pulse,
        input  cap_period,
        input  cap_high,
        input  cap_valid,
        input  cap_timeout,
        input  cap_busy,
        input  cap_state
    );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture
// Measures an incoming PWM waveform: period (rise to rise) and high time,
// both in clock cycles, published with a one-cycle cap_valid strobe.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   cap   : pwm_capture_if.slave (enable, pulse in; results, strobes,
//           busy and debug state out)
// Parameters:
//   WIDTH   : counter/result width
//   TIMEOUT : cycles without a rise before cap_timeout (0 disables)
// Configuration macro:
//   PWM_CAPTURE_SYNC_EN : when defined, cap_pulse passes through a 2-flop
//   synchronizer first (2 extra cycles of latency, same results).
module pwm_capture #(
    parameter int          WIDTH   = 32,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic         clock,
    input  logic         reset,
    pwm_capture_if.slave cap
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ALL_ONES   = '1;
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
    localparam logic [WIDTH-1:0] TIMEOUT_W  = WIDTH'(TIMEOUT);
    localparam bit               TIMEOUT_EN = (TIMEOUT != 0);

    state_t           state_q, state_d;
    logic             p_in;
    logic             p_r, p_d;
    logic             rise;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hcnt_q, hcnt_d;
    logic [WIDTH-1:0] cnt_inc, hcnt_inc;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

`ifdef PWM_CAPTURE_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], cap.cap_pulse};
        end
    end

    assign p_in = sync_q[1];
`else
    assign p_in = cap.cap_pulse;
`endif

    // One-cycle-old copy of the sampled input gives the rising edge.
    assign rise = p_r & ~p_d;

    // Saturating increments: a stuck counter reports all-ones rather than
    // wrapping to a small, plausible-looking value.
    assign cnt_inc  = (cnt_q == ALL_ONES) ? cnt_q : cnt_q + ONE;
    assign hcnt_inc = (p_r && (hcnt_q != ALL_ONES)) ? hcnt_q + ONE : hcnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            p_r       <= 1'b0;
            p_d       <= 1'b0;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_r       <= p_in;
            p_d       <= p_r;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        hcnt_d    = '0;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;

        if (!cap.cap_enable) begin
            // Disabled: drop any partial measurement, keep last results.
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // First rise only establishes the reference edge.
                    if (rise) begin
                        state_d = RUN;
                        cnt_d   = ONE;
                        hcnt_d  = ONE;
                    end
                end
                RUN: begin
                    if (rise) begin
                        // Rise wins over a coincident timeout.
                        period_d = cnt_q;
                        high_d   = hcnt_q;
                        valid_d  = 1'b1;
                        cnt_d    = ONE;
                        hcnt_d   = ONE;
                    end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_W)) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        cnt_d  = cnt_inc;
                        hcnt_d = hcnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign cap.cap_period  = period_q;
    assign cap.cap_high    = high_q;
    assign cap.cap_valid   = valid_q;
    assign cap.cap_timeout = timeout_q;
    assign cap.cap_busy    = (state_q == RUN);
    assign cap.cap_state   = state_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture
// Directed bench for pwm_capture. Two instances share clock and reset:
// dut_a with TIMEOUT=16 and dut_b with TIMEOUT=4. Each scenario task drives
// a pulse waveform, records the cycle of every input rise, and compares the
// recorded strobes against hand-computed period/high values at the cycle
// rise + LAT.
module tb_pwm_capture;

`ifdef PWM_CAPTURE_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    logic a_last = 1'b0;
    logic b_last = 1'b0;

    pwm_capture_if #(.WIDTH(32)) a_if ();
    pwm_capture_if #(.WIDTH(32)) b_if ();

    pwm_capture #(.WIDTH(32), .TIMEOUT(16)) dut_a (
        .clock (clk),
        .reset (reset),
        .cap   (a_if.slave)
    );

    pwm_capture #(.WIDTH(32), .TIMEOUT(4)) dut_b (
        .clock (clk),
        .reset (reset),
        .cap   (b_if.slave)
    );

    // Clock/reset block.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation queues (strobe cycle, period, high) and expectations.
    logic [31:0] a_vc_q[$], a_vp_q[$], a_vh_q[$], a_to_q[$];
    logic [31:0] b_vc_q[$], b_vp_q[$], b_vh_q[$], b_to_q[$];
    logic [31:0] rise_q[$];
    logic [31:0] exp_cyc_q[$], exp_per_q[$], exp_high_q[$];

    always @(negedge clk) begin
        if (a_if.cap_valid === 1'b1) begin
            a_vc_q.push_back(cyc);
            a_vp_q.push_back(a_if.cap_period);
            a_vh_q.push_back(a_if.cap_high);
        end
        if (a_if.cap_timeout === 1'b1) a_to_q.push_back(cyc);
        if (b_if.cap_valid === 1'b1) begin
            b_vc_q.push_back(cyc);
            b_vp_q.push_back(b_if.cap_period);
            b_vh_q.push_back(b_if.cap_high);
        end
        if (b_if.cap_timeout === 1'b1) b_to_q.push_back(cyc);
    end

    // Driver tasks.
    task automatic drive(input bit sel, input logic b);
        @(posedge clk);
        #1;
        if (sel) begin
            b_if.cap_pulse = b;
            if (b && !b_last) rise_q.push_back(cyc);
            b_last = b;
        end else begin
            a_if.cap_pulse = b;
            if (b && !a_last) rise_q.push_back(cyc);
            a_last = b;
        end
    endtask

    task automatic per(input bit sel, input int h, input int l);
        for (int i = 0; i < h; i++) drive(sel, 1'b1);
        for (int i = 0; i < l; i++) drive(sel, 1'b0);
    endtask

    task automatic enable_on(input bit sel);
        @(posedge clk);
        #1;
        if (sel) b_if.cap_enable = 1'b1;
        else a_if.cap_enable = 1'b1;
    endtask

    task automatic quiesce();
        @(posedge clk);
        #1;
        a_if.cap_enable = 1'b0;
        a_if.cap_pulse  = 1'b0;
        b_if.cap_enable = 1'b0;
        b_if.cap_pulse  = 1'b0;
        a_last = 1'b0;
        b_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic clear_all();
        a_vc_q.delete(); a_vp_q.delete(); a_vh_q.delete(); a_to_q.delete();
        b_vc_q.delete(); b_vp_q.delete(); b_vh_q.delete(); b_to_q.delete();
        rise_q.delete();
        exp_cyc_q.delete(); exp_per_q.delete(); exp_high_q.delete();
    endtask

    // Rise number i publishes the period that began at rise i-1.
    task automatic expect_runs(input int first, input int n,
                               input logic [31:0] p, input logic [31:0] h);
        for (int i = first; i < first + n; i++) begin
            exp_cyc_q.push_back(rise_q[i] + LAT);
            exp_per_q.push_back(p);
            exp_high_q.push_back(h);
        end
    endtask

    task automatic test_reset();
        a_if.cap_enable = 1'b0;
        a_if.cap_pulse  = 1'b0;
        b_if.cap_enable = 1'b0;
        b_if.cap_pulse  = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (a_if.cap_period !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_period: got %0d, expected 0", a_if.cap_period);
        end
        vectors++;
        if (a_if.cap_high !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_high: got %0d, expected 0", a_if.cap_high);
        end
        vectors++;
        if ({a_if.cap_valid, a_if.cap_timeout, a_if.cap_busy, a_if.cap_state} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got v/t/b/s %b%b%b%b, expected 0000",
                     a_if.cap_valid, a_if.cap_timeout, a_if.cap_busy, a_if.cap_state);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_steady();
        clear_all();
        enable_on(0);
        repeat (5) per(0, 2, 2);
        drive(0, 1'b1);
        repeat (5) drive(0, 1'b1);
        @(negedge clk);
        #1;
        vectors++;
        if (a_if.cap_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL steady_busy: got %b, expected 1", a_if.cap_busy);
        end
        expect_runs(1, 5, 32'd4, 32'd2);
        vectors++;
        if (a_vc_q.size() != exp_cyc_q.size() || a_to_q.size() != 0) begin
            miscompares++;
            $display("FAIL steady_count: got %0d strobes %0d timeouts, expected %0d and 0",
                     a_vc_q.size(), a_to_q.size(), exp_cyc_q.size());
        end
        for (int i = 0; i < exp_cyc_q.size() && i < a_vc_q.size(); i++) begin
            vectors++;
            if (a_vc_q[i] !== exp_cyc_q[i] || a_vp_q[i] !== exp_per_q[i] || a_vh_q[i] !== exp_high_q[i]) begin
                miscompares++;
                $display("FAIL steady_strobe%0d: got cyc %0d %0d/%0d, expected cyc %0d %0d/%0d", i,
                         a_vc_q[i], a_vp_q[i], a_vh_q[i], exp_cyc_q[i], exp_per_q[i], exp_high_q[i]);
            end
        end
        quiesce();
    endtask

    task automatic test_pattern_change();
        clear_all();
        enable_on(0);
        repeat (2) per(0, 2, 2);
        repeat (3) per(0, 3, 3);
        repeat (2) per(0, 1, 4);
        drive(0, 1'b1);
        repeat (5) drive(0, 1'b1);
        @(negedge clk);
        #1;
        expect_runs(1, 2, 32'd4, 32'd2);
        expect_runs(3, 3, 32'd6, 32'd3);
        expect_runs(6, 2, 32'd5, 32'd1);
        vectors++;
        if (a_vc_q.size() != exp_cyc_q.size() || a_to_q.size() != 0) begin
            miscompares++;
            $display("FAIL change_count: got %0d strobes %0d timeouts, expected %0d and 0",
                     a_vc_q.size(), a_to_q.size(), exp_cyc_q.size());
        end
        for (int i = 0; i < exp_cyc_q.size() && i < a_vc_q.size(); i++) begin
            vectors++;
            if (a_vc_q[i] !== exp_cyc_q[i] || a_vp_q[i] !== exp_per_q[i] || a_vh_q[i] !== exp_high_q[i]) begin
                miscompares++;
                $display("FAIL change_strobe%0d: got cyc %0d %0d/%0d, expected cyc %0d %0d/%0d", i,
                         a_vc_q[i], a_vp_q[i], a_vh_q[i], exp_cyc_q[i], exp_per_q[i], exp_high_q[i]);
            end
        end
        quiesce();
    endtask

    task automatic test_min_period();
        clear_all();
        enable_on(0);
        repeat (4) per(0, 1, 1);
        drive(0, 1'b1);
        repeat (5) drive(0, 1'b1);
        @(negedge clk);
        #1;
        expect_runs(1, 4, 32'd2, 32'd1);
        vectors++;
        if (a_vc_q.size() != exp_cyc_q.size()) begin
            miscompares++;
            $display("FAIL minper_count: got %0d strobes, expected %0d", a_vc_q.size(), exp_cyc_q.size());
        end
        for (int i = 0; i < exp_cyc_q.size() && i < a_vc_q.size(); i++) begin
            vectors++;
            if (a_vc_q[i] !== exp_cyc_q[i] || a_vp_q[i] !== exp_per_q[i] || a_vh_q[i] !== exp_high_q[i]) begin
                miscompares++;
                $display("FAIL minper_strobe%0d: got cyc %0d %0d/%0d, expected cyc %0d %0d/%0d", i,
                         a_vc_q[i], a_vp_q[i], a_vh_q[i], exp_cyc_q[i], exp_per_q[i], exp_high_q[i]);
            end
        end
        quiesce();
    endtask

    task automatic test_timeout();
        logic [31:0] last_rise;
        clear_all();
        enable_on(0);
        repeat (2) per(0, 3, 3);
        per(0, 3, 22);
        @(negedge clk);
        #1;
        last_rise = rise_q[2];
        expect_runs(1, 2, 32'd6, 32'd3);
        vectors++;
        if (a_to_q.size() != 1) begin
            miscompares++;
            $display("FAIL timeout_count: got %0d timeouts, expected 1", a_to_q.size());
        end else begin
            vectors++;
            if (a_to_q[0] !== last_rise + LAT + 16) begin
                miscompares++;
                $display("FAIL timeout_cycle: got %0d, expected %0d", a_to_q[0], last_rise + LAT + 16);
            end
        end
        vectors++;
        if ({a_if.cap_busy, a_if.cap_period, a_if.cap_high} !== {1'b0, 32'd6, 32'd3}) begin
            miscompares++;
            $display("FAIL timeout_hold: got busy %b %0d/%0d, expected busy 0 6/3",
                     a_if.cap_busy, a_if.cap_period, a_if.cap_high);
        end
        vectors++;
        if (a_vc_q.size() != exp_cyc_q.size()) begin
            miscompares++;
            $display("FAIL timeout_strobes: got %0d, expected %0d", a_vc_q.size(), exp_cyc_q.size());
        end
        for (int i = 0; i < exp_cyc_q.size() && i < a_vc_q.size(); i++) begin
            vectors++;
            if (a_vc_q[i] !== exp_cyc_q[i] || a_vp_q[i] !== exp_per_q[i] || a_vh_q[i] !== exp_high_q[i]) begin
                miscompares++;
                $display("FAIL timeout_strobe%0d: got cyc %0d %0d/%0d, expected cyc %0d %0d/%0d", i,
                         a_vc_q[i], a_vp_q[i], a_vh_q[i], exp_cyc_q[i], exp_per_q[i], exp_high_q[i]);
            end
        end
        // After the timeout the next rise only re-arms.
        clear_all();
        repeat (2) per(0, 2, 2);
        drive(0, 1'b1);
        repeat (5) drive(0, 1'b1);
        @(negedge clk);
        #1;
        expect_runs(1, 2, 32'd4, 32'd2);
        vectors++;
        if (a_vc_q.size() != exp_cyc_q.size() || a_to_q.size() != 0) begin
            miscompares++;
            $display("FAIL rearm_count: got %0d strobes %0d timeouts, expected %0d and 0",
                     a_vc_q.size(), a_to_q.size(), exp_cyc_q.size());
        end
        for (int i = 0; i < exp_cyc_q.size() && i < a_vc_q.size(); i++) begin
            vectors++;
            if (a_vc_q[i] !== exp_cyc_q[i] || a_vp_q[i] !== exp_per_q[i] || a_vh_q[i] !== exp_high_q[i]) begin
                miscompares++;
                $display("FAIL rearm_strobe%0d: got cyc %0d %0d/%0d, expected cyc %0d %0d/%0d", i,
                         a_vc_q[i], a_vp_q[i], a_vh_q[i], exp_cyc_q[i], exp_per_q[i], exp_high_q[i]);
            end
        end
        quiesce();
    endtask

    task automatic test_back_to_back_timeout();
        clear_all();
        enable_on(1);
        repeat (5) per(1, 1, 3);
        drive(1, 1'b1);
        repeat (3) drive(1, 1'b1);
        quiesce();
        expect_runs(1, 5, 32'd4, 32'd1);
        vectors++;
        if (b_vc_q.size() != exp_cyc_q.size() || b_to_q.size() != 0) begin
            miscompares++;
            $display("FAIL simul_count: got %0d strobes %0d timeouts, expected %0d and 0",
                     b_vc_q.size(), b_to_q.size(), exp_cyc_q.size());
        end
        for (int i = 0; i < exp_cyc_q.size() && i < b_vc_q.size(); i++) begin
            vectors++;
            if (b_vc_q[i] !== exp_cyc_q[i] || b_vp_q[i] !== exp_per_q[i] || b_vh_q[i] !== exp_high_q[i]) begin
                miscompares++;
                $display("FAIL simul_strobe%0d: got cyc %0d %0d/%0d, expected cyc %0d %0d/%0d", i,
                         b_vc_q[i], b_vp_q[i], b_vh_q[i], exp_cyc_q[i], exp_per_q[i], exp_high_q[i]);
            end
        end
    endtask

    // use_reset=1: one-cycle reset mid-period; 0: cap_enable dropped instead.
    task automatic test_mid_abort(input bit use_reset);
        clear_all();
        enable_on(0);
        repeat (3) per(0, 2, 2);
        per(0, 2, 3);
        if (use_reset) reset = 1'b1;
        else a_if.cap_enable = 1'b0;
        drive(0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (use_reset) begin
            if ({a_if.cap_period, a_if.cap_high} !== 64'd0) begin
                miscompares++;
                $display("FAIL abort_reset_vals: got %0d/%0d, expected 0/0", a_if.cap_period, a_if.cap_high);
            end
        end else begin
            if ({a_if.cap_period, a_if.cap_high} !== {32'd4, 32'd2}) begin
                miscompares++;
                $display("FAIL abort_enable_vals: got %0d/%0d, expected 4/2", a_if.cap_period, a_if.cap_high);
            end
        end
        vectors++;
        if ({a_if.cap_valid, a_if.cap_timeout, a_if.cap_busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL abort_flags(reset=%0d): got v/t/b %b%b%b, expected 000", use_reset,
                     a_if.cap_valid, a_if.cap_timeout, a_if.cap_busy);
        end
        expect_runs(1, 3, 32'd4, 32'd2);
        #1;
        vectors++;
        if (a_vc_q.size() != exp_cyc_q.size()) begin
            miscompares++;
            $display("FAIL abort_pre_count(reset=%0d): got %0d, expected %0d", use_reset,
                     a_vc_q.size(), exp_cyc_q.size());
        end
        clear_all();
        drive(0, 1'b0);
        a_if.cap_enable = 1'b1;
        drive(0, 1'b0);
        repeat (2) per(0, 2, 2);
        drive(0, 1'b1);
        repeat (5) drive(0, 1'b1);
        @(negedge clk);
        #1;
        expect_runs(1, 2, 32'd4, 32'd2);
        vectors++;
        if (a_vc_q.size() != exp_cyc_q.size() || a_to_q.size() != 0) begin
            miscompares++;
            $display("FAIL abort_post_count(reset=%0d): got %0d strobes %0d timeouts, expected %0d and 0",
                     use_reset, a_vc_q.size(), a_to_q.size(), exp_cyc_q.size());
        end
        for (int i = 0; i < exp_cyc_q.size() && i < a_vc_q.size(); i++) begin
            vectors++;
            if (a_vc_q[i] !== exp_cyc_q[i] || a_vp_q[i] !== exp_per_q[i] || a_vh_q[i] !== exp_high_q[i]) begin
                miscompares++;
                $display("FAIL abort_strobe%0d(reset=%0d): got cyc %0d %0d/%0d, expected cyc %0d %0d/%0d",
                         i, use_reset, a_vc_q[i], a_vp_q[i], a_vh_q[i],
                         exp_cyc_q[i], exp_per_q[i], exp_high_q[i]);
            end
        end
        quiesce();
    endtask

    initial begin
        test_reset();
        test_steady();
        test_pattern_change();
        test_min_period();
        test_timeout();
        test_back_to_back_timeout();
        test_mid_abort(1'b1);
        test_mid_abort(1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform and reports its period and high time in clock cycles; it is the receive-side counterpart of the `pwm` generator. It sits between an external pulse input and the control logic, which consumes `cap_period`/`cap_high` on each `cap_valid` strobe. It is used for feedback from servo/encoder-style PWM sources and for loopback checks of our own generator outputs.

## Interface
- `WIDTH`, 32: width of the period/high counters and the result outputs.
- `TIMEOUT`, 1000000: cycles without a rising edge before a timeout is declared. 0 disables timeout. Must be ≤ 2^WIDTH−1.
- `clock`  in  1  single system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cap_enable`  in  1  measurement enable; low forces IDLE.
- `cap_pulse`  in  1  PWM input, possibly asynchronous.
- `cap_period`  out  WIDTH  cycles from one rising edge to the next.
- `cap_high`  out  WIDTH  cycles the input was high within that period.
- `cap_valid`  out  1  one-cycle strobe: new `cap_period`/`cap_high` are valid.
- `cap_timeout`  out  1  one-cycle strobe: no rising edge within `TIMEOUT` cycles.
- `cap_busy`  out  1  high while in RUN, i.e. a reference edge is held.

## Operation
- Input stage: `p_r` <= `cap_pulse` every cycle, then `p_d` <= `p_r`. A rise is `p_r & ~p_d`.
- Counters: `cnt` and `hcnt`, both WIDTH bits, saturating at all-ones.
  - On a rise, both are loaded with 1.
  - Otherwise `cnt` increments every cycle, and `hcnt` increments when `p_r` is 1.
- States:
  - IDLE: counters held at 0. A rise with `cap_enable`=1 goes to RUN and loads the counters. Nothing is published.
  - RUN, rise: `cap_period` <= `cnt`, `cap_high` <= `hcnt`, `cap_valid` <= 1, counters reload to 1, stay in RUN.
  - RUN, no rise, `TIMEOUT`≠0 and `cnt` == `TIMEOUT`: `cap_timeout` <= 1, go to IDLE. `cap_period`/`cap_high` hold.
- Priority, highest first: `reset` > `cap_enable`=0 (go to IDLE, no strobes) > rise > timeout. A rise on the same cycle as `cnt`==`TIMEOUT` publishes normally, with no timeout.
- The result is reported in the same units the input was sampled in:
  - A waveform high for H samples and low for L samples gives `cap_period`=H+L and `cap_high`=H.
  - Constant 0%/100% duty produces no rises, so it ends in a timeout. `cap_pulse` constant high with `cap_busy`=0 identifies the 100% case.
- With `TIMEOUT`=0, periods longer than 2^WIDTH−1 publish all-ones (saturated).
- `cap_period`/`cap_high` change only on a `cap_valid` cycle and hold otherwise.

## Timing
- Reset values: `cap_period`=0, `cap_high`=0, `cap_valid`=0, `cap_timeout`=0, `cap_busy`=0, state IDLE, `p_r`=`p_d`=0, counters 0.
- Latency: `cap_pulse` rising before edge k gives `p_r`=1 after edge k. The rise is acted on at edge k+1, so `cap_valid` is high for the cycle following edge k+1 (2 cycles without the synchronizer).
- `cap_valid` and `cap_timeout` are single-cycle and never asserted together.
- Minimum measurable period is 2 cycles (H=1, L=1). Minimum high time is 1 cycle.
- Reset or `cap_enable` low during RUN discards the partial measurement. The first rise afterwards only arms the block.

## Configuration
- `PWM_CAPTURE_SYNC_EN`: when defined, `cap_pulse` passes through a 2-flop synchronizer before `p_r`.
  - Adds 2 cycles of latency: `cap_valid` appears 4 cycles after the input edge.
  - `cap_period`/`cap_high` values are unchanged.
- Without the macro, `cap_pulse` must already be synchronous to `clock`.

## Test plan
- Steady pattern, `cap_enable`=1, `TIMEOUT`=16: repeat H=2, L=2.
  - First rise gives no `cap_valid`.
  - Every later rise gives `cap_valid` with `cap_period`=4, `cap_high`=2, every 4 cycles, 2 cycles after the input edge.
- Pattern change: switch to H=3, L=3, then H=1, L=4.
  - The first period after the switch reports 4/2 (still the old pattern).
  - Then 6/3 repeating, then 5/1.
- Timeout: after a 6/3 period, hold `cap_pulse` low.
  - `cap_timeout` pulses once, 16 cycles after the last rise was acted on.
  - `cap_busy`→0, outputs hold 6/3.
  - The next rise arms only; the following rise publishes.
- Simultaneous rise and timeout: with `TIMEOUT`=4, drive H=1, L=3.
  - `cap_valid` with 4/1 every period, `cap_timeout` never asserted.
- Mid-operation reset and enable: assert `reset` for 1 cycle, or drop `cap_enable`, in the middle of a period.
  - All outputs return to their reset values (`reset` case) or hold (`cap_enable` case), with no strobes.
  - The first post-release rise arms; the second publishes a correct 4/2.
- Macro build (`PWM_CAPTURE_SYNC_EN`): rerun the steady 2/2 scenario.
  - Identical values; `cap_valid` is 2 cycles later.
